// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the switch/button input conditioner.
package cpu_io_pkg;

    localparam int unsigned NUM_SWITCHES = 4;

    // Debounced push-button tracking state.
    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } btn_state_e;

endpackage : cpu_io_pkg

// File: rtl/switch_input_conditioner_if.sv
// Raw switch inputs, conditioned outputs and the CPU capture handshake.
interface switch_input_conditioner_if;
    import cpu_io_pkg::*;

    logic [NUM_SWITCHES-1:0] SWITCHES;
    logic                    PSWITCH;
    logic [NUM_SWITCHES-1:0] sw_stable;
    logic                    press_pulse;
    logic [NUM_SWITCHES-1:0] data;
    logic                    data_valid;
    logic                    data_ack;
    logic                    overrun;

    // Board / CPU side: drives the raw inputs and the acknowledge.
    modport master (
        output SWITCHES, PSWITCH, data_ack,
        input  sw_stable, press_pulse, data, data_valid, overrun
    );

    // Conditioner side.
    modport slave (
        input  SWITCHES, PSWITCH, data_ack,
        output sw_stable, press_pulse, data, data_valid, overrun
    );

endinterface : switch_input_conditioner_if

// File: rtl/switch_input_conditioner_debounce_bit.sv
// One input bit: 2-flop synchronizer, optional polarity flip, debounce counter.
// The synchronizer resets to the raw released level (INVERT) so the
// normalized level starts at 0 without a spurious change after reset.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          INVERT          = 1'b0
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             w_in;

    assign w_in    = r_sync2 ^ INVERT;
    assign o_level = r_level;

    // Synchronize, then accept a new level only after DEBOUNCE_CYCLES differing cycles.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_sync1 <= INVERT;
            r_sync2 <= INVERT;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (w_in == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= w_in;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule : debounce_bit

// File: rtl/switch_input_conditioner.sv
// Debounces four slide switches and a push button; each button press
// captures the debounced switch value for the CPU with an ack/overrun handshake.
module switch_input_conditioner
    import cpu_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          PSW_ACTIVE_LOW  = 1'b1
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    switch_input_conditioner_if.slave  bus
);

    logic [NUM_SWITCHES-1:0] w_sw_level;
    logic                    w_btn;

    btn_state_e              r_state;
    btn_state_e              w_state_nxt;
    logic                    w_press;

    logic                    r_press_pulse;
    logic [NUM_SWITCHES-1:0] r_data;
    logic                    r_data_valid;
    logic                    r_overrun;
    logic [NUM_SWITCHES-1:0] w_data_nxt;
    logic                    w_valid_nxt;
    logic                    w_ovr_nxt;

    // Per-switch debouncers; their level registers drive sw_stable directly.
    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (1'b0)
        ) u_sw (
            .clk      (clk),
            .sync_rst (sync_rst),
            .i_raw    (bus.SWITCHES[g]),
            .o_level  (w_sw_level[g])
        );
    end

    // Button debouncer; output is normalized to 1 = pressed.
    debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .INVERT          (PSW_ACTIVE_LOW)
    ) u_btn (
        .clk      (clk),
        .sync_rst (sync_rst),
        .i_raw    (bus.PSWITCH),
        .o_level  (w_btn)
    );

    // Button state register.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, press detection and capture/ack/overrun handshake.
    // A press coinciding with an ack is treated as ack-then-capture.
    always_comb begin
        w_state_nxt = r_state;
        w_press     = 1'b0;
        w_data_nxt  = r_data;
        w_valid_nxt = r_data_valid;
        w_ovr_nxt   = r_overrun;

        case (r_state)
            IDLE: begin
                if (w_btn) begin
                    w_state_nxt = HELD;
                    w_press     = 1'b1;
                end
            end
            HELD: begin
                if (!w_btn) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase

        if (bus.data_ack && r_data_valid) begin
            w_valid_nxt = 1'b0;
        end
        if (bus.data_ack) begin
            w_ovr_nxt = 1'b0;
        end

        if (w_press) begin
            if (!r_data_valid || bus.data_ack) begin
                w_data_nxt  = w_sw_level;
                w_valid_nxt = 1'b1;
                if (r_data_valid) begin
                    w_ovr_nxt = r_overrun;
                end
            end else begin
                w_ovr_nxt = 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_press_pulse <= 1'b0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_press_pulse <= w_press;
            r_data        <= w_data_nxt;
            r_data_valid  <= w_valid_nxt;
            r_overrun     <= w_ovr_nxt;
        end
    end

    assign bus.sw_stable   = w_sw_level;
    assign bus.press_pulse = r_press_pulse;
    assign bus.data        = r_data;
    assign bus.data_valid  = r_data_valid;
    assign bus.overrun     = r_overrun;

endmodule : switch_input_conditioner

// File: tb/tb_switch_input_conditioner.sv
// Scoreboard bench for switch_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_switch_input_conditioner;

    localparam int unsigned DC      = 4;
    localparam int          LAT_SW  = DC + 2;
    localparam int          LAT_BTN = DC + 3;

    typedef struct {
        logic [3:0] val;
        int         cyc;
    } sw_exp_t;

    typedef struct {
        logic [3:0] data;
        logic       valid;
        logic       ovr;
        int         cyc;
    } press_exp_t;

    logic clk = 1'b0;
    logic sync_rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    sw_exp_t    exp_sw[$];
    press_exp_t exp_press[$];

    switch_input_conditioner_if bus_if ();

    switch_input_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .PSW_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_sw(input logic [3:0] v);
        sw_exp_t e;
        e.val = v;
        e.cyc = cyc + LAT_SW;
        exp_sw.push_back(e);
    endtask

    task automatic push_press(input logic [3:0] d, input logic v, input logic o);
        press_exp_t e;
        e.data  = d;
        e.valid = v;
        e.ovr   = o;
        e.cyc   = cyc + LAT_BTN;
        exp_press.push_back(e);
    endtask

    // Monitor: pops an expectation whenever sw_stable changes or press_pulse fires.
    initial begin : monitor
        logic [3:0] prev_sw;
        sw_exp_t    es;
        press_exp_t ep;
        prev_sw = 4'h0;
        forever begin
            @(negedge clk);
            if (!sync_rst && bus_if.sw_stable !== prev_sw) begin
                n_checks++;
                if (exp_sw.size() == 0) begin
                    n_errors++;
                    $display("FAIL sw_unexpected: got %b at cycle %0d, no change expected",
                             bus_if.sw_stable, cyc);
                end else begin
                    es = exp_sw.pop_front();
                    if (bus_if.sw_stable !== es.val || cyc != es.cyc) begin
                        n_errors++;
                        $display("FAIL sw_change: got %b at cycle %0d expected %b at cycle %0d",
                                 bus_if.sw_stable, cyc, es.val, es.cyc);
                    end
                end
            end
            prev_sw = bus_if.sw_stable;
            if (bus_if.press_pulse === 1'b1) begin
                n_checks++;
                if (exp_press.size() == 0) begin
                    n_errors++;
                    $display("FAIL press_unexpected: press_pulse at cycle %0d", cyc);
                end else begin
                    ep = exp_press.pop_front();
                    if (bus_if.data !== ep.data || bus_if.data_valid !== ep.valid ||
                        bus_if.overrun !== ep.ovr || cyc != ep.cyc) begin
                        n_errors++;
                        $display("FAIL press: got data=%b valid=%b ovr=%b cyc=%0d expected data=%b valid=%b ovr=%b cyc=%0d",
                                 bus_if.data, bus_if.data_valid, bus_if.overrun, cyc,
                                 ep.data, ep.valid, ep.ovr, ep.cyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int wait_cnt;
        sync_rst            = 1'b1;
        bus_if.SWITCHES     = 4'b0000;
        bus_if.PSWITCH      = 1'b1;
        bus_if.data_ack     = 1'b0;

        // Reset with button released.
        step(3);
        check("rst_sw_stable",   32'(bus_if.sw_stable),   32'h0);
        check("rst_press_pulse", 32'(bus_if.press_pulse), 32'h0);
        check("rst_data",        32'(bus_if.data),        32'h0);
        check("rst_data_valid",  32'(bus_if.data_valid),  32'h0);
        check("rst_overrun",     32'(bus_if.overrun),     32'h0);
        sync_rst = 1'b0;
        step(10);
        check("post_rst_no_press", 32'(bus_if.press_pulse), 32'h0);

        // Latency of a held change.
        bus_if.SWITCHES = 4'b1010;
        push_sw(4'b1010);
        step(10);
        bus_if.SWITCHES = 4'b0000;
        push_sw(4'b0000);
        step(10);

        // Three-cycle glitch on bit 0 is rejected.
        bus_if.SWITCHES = 4'b0001;
        step(3);
        bus_if.SWITCHES = 4'b0000;
        step(10);
        check("glitch_sw_stable", 32'(bus_if.sw_stable), 32'h0);

        // Capture on a long press, then acknowledge.
        bus_if.SWITCHES = 4'b0101;
        push_sw(4'b0101);
        step(10);
        bus_if.PSWITCH = 1'b0;
        push_press(4'b0101, 1'b1, 1'b0);
        step(20);
        bus_if.PSWITCH = 1'b1;
        step(10);
        check("cap_data",       32'(bus_if.data),       32'h5);
        check("cap_data_valid", 32'(bus_if.data_valid), 32'h1);
        bus_if.data_ack = 1'b1;
        step(1);
        bus_if.data_ack = 1'b0;
        check("ack_clears_valid", 32'(bus_if.data_valid), 32'h0);
        check("ack_overrun",      32'(bus_if.overrun),    32'h0);

        // Overrun: second press while the first capture is unacknowledged.
        bus_if.PSWITCH = 1'b0;
        push_press(4'b0101, 1'b1, 1'b0);
        step(10);
        bus_if.PSWITCH = 1'b1;
        step(10);
        bus_if.SWITCHES = 4'b1111;
        push_sw(4'b1111);
        step(10);
        bus_if.PSWITCH = 1'b0;
        push_press(4'b0101, 1'b1, 1'b1);
        step(10);
        bus_if.PSWITCH = 1'b1;
        step(10);
        check("ovr_data",     32'(bus_if.data),       32'h5);
        check("ovr_valid",    32'(bus_if.data_valid), 32'h1);
        check("ovr_flag",     32'(bus_if.overrun),    32'h1);

        // Press and ack in the same cycle: reload, valid stays, overrun unchanged.
        bus_if.PSWITCH = 1'b0;
        push_press(4'b1111, 1'b1, 1'b1);
        step(LAT_BTN - 1);
        bus_if.data_ack = 1'b1;
        step(1);
        bus_if.data_ack = 1'b0;
        check("pa_data",  32'(bus_if.data),       32'hF);
        check("pa_valid", 32'(bus_if.data_valid), 32'h1);
        check("pa_ovr",   32'(bus_if.overrun),    32'h1);
        step(9);
        bus_if.PSWITCH = 1'b1;
        step(10);
        bus_if.data_ack = 1'b1;
        step(1);
        bus_if.data_ack = 1'b0;
        check("ack2_valid", 32'(bus_if.data_valid), 32'h0);
        check("ack2_ovr",   32'(bus_if.overrun),    32'h0);

        // Reset two cycles into a debounce; the change must restart from scratch.
        bus_if.SWITCHES = 4'b0110;
        step(3);
        sync_rst = 1'b1;
        step(2);
        sync_rst = 1'b0;
        check("mrst_sw_stable", 32'(bus_if.sw_stable),   32'h0);
        check("mrst_data",      32'(bus_if.data),        32'h0);
        check("mrst_valid",     32'(bus_if.data_valid),  32'h0);
        check("mrst_pulse",     32'(bus_if.press_pulse), 32'h0);
        push_sw(4'b0110);
        step(12);

        // Drain the scoreboard.
        wait_cnt = 0;
        while ((exp_sw.size() != 0 || exp_press.size() != 0) && wait_cnt < 20) begin
            step(1);
            wait_cnt++;
        end
        check("sw_queue_drained",    32'(exp_sw.size()),    32'h0);
        check("press_queue_drained", 32'(exp_press.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_switch_input_conditioner

// File: doc/switch_input_conditioner.md
SWITCH_INPUT_CONDITIONER -- requirements
Module: switch_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required before an input change is accepted (10 ms at 50 MHz).
REQ-002 SHALL have parameter PSW_ACTIVE_LOW, default 1; 1 means raw PSWITCH=0 is pressed.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port sync_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port SWITCHES  input  4  raw asynchronous slide switches.
REQ-006 SHALL have port PSWITCH  input  1  raw asynchronous push button.
REQ-007 SHALL have port sw_stable  output  4  debounced switch levels.
REQ-008 SHALL have port press_pulse  output  1  one-cycle strobe on each debounced press.
REQ-009 SHALL have port data  output  4  sw_stable captured at the press.
REQ-010 SHALL have port data_valid  output  1  data holds an unconsumed capture.
REQ-011 SHALL have port data_ack  input  1  CPU consumes data; sampled every cycle.
REQ-012 SHALL have port overrun  output  1  sticky flag, press lost while data_valid was set.

Function
REQ-013 SHALL pass each of the 5 raw inputs through a 2-flop synchronizer before any other use.
REQ-014 SHALL normalize PSWITCH to active-high "pressed" after synchronization, per PSW_ACTIVE_LOW.
REQ-015 SHALL debounce each bit independently with its own counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronized input equals the debounced level.
  - Counter increments while the two differ.
  - The debounced level takes the new value, and the counter clears, on the edge where the input has differed for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 SHALL give a latency of exactly DEBOUNCE_CYCLES+2 cycles from a held raw change to sw_stable; any pulse shorter than DEBOUNCE_CYCLES cycles after synchronization SHALL produce no output change.
REQ-017 SHALL run a button FSM with states IDLE (released) and HELD.
  - IDLE->HELD when the debounced button becomes pressed.
  - HELD->IDLE when it becomes released.
  - No other transitions.
REQ-018 SHALL, on the IDLE->HELD edge, register press_pulse=1 for exactly one cycle; holding the button SHALL produce no further pulses.
REQ-019 SHALL, on a press with data_valid=0, load data with the sw_stable value present in the same cycle and set data_valid=1.
REQ-020 SHALL clear data_valid on the edge after data_ack=1 is sampled with data_valid=1; data_ack with data_valid=0 SHALL be ignored.
REQ-021 SHALL, on a press with data_valid=1 and data_ack=0, leave data unchanged and set overrun=1.
REQ-022 SHALL treat a press and data_ack in the same cycle as ack-then-capture: data reloads, data_valid stays 1, overrun unchanged.
REQ-023 SHALL clear overrun on any sampled data_ack=1 unless REQ-021 sets it in the same cycle.

Reset
REQ-024 SHALL, while sync_rst=1 at a clock edge, clear every counter.
  - Set sw_stable=0, data=0, data_valid=0, press_pulse=0, overrun=0, FSM=IDLE.
  - Preload the synchronizer and debounced-button flops to the released level.
REQ-025 SHALL abandon any debounce in progress on reset; a change after reset SHALL need a full DEBOUNCE_CYCLES again.
REQ-026 SHALL NOT emit press_pulse at reset release while the button is released.

Structure
REQ-027 SHALL place NUM_SWITCHES=4 and the FSM state enum (IDLE, HELD) in the shared package cpu_io_pkg.
REQ-028 SHALL use a sub-module debounce_bit (sync plus counter plus level, parameter DEBOUNCE_CYCLES), instantiated 5 times.
REQ-029 SHALL keep all outputs registered, with no combinational path from any input to any output.

Verification (DEBOUNCE_CYCLES=4, PSW_ACTIVE_LOW=1)
REQ-030 SHALL cover reset: assert sync_rst 3 cycles with PSWITCH=1 -> all outputs 0; no press_pulse after release.
REQ-031 SHALL cover latency: SWITCHES 0000->1010 held -> sw_stable=1010 exactly 6 cycles later, not earlier.
REQ-032 SHALL cover glitch rejection: SWITCHES[0] high 3 cycles then low -> sw_stable stays 0000.
REQ-033 SHALL cover capture: SWITCHES=0101 settled, PSWITCH low 20 cycles -> exactly one press_pulse, data=0101, data_valid=1 until data_ack, cleared the next cycle.
REQ-034 SHALL cover overrun: unacked capture 0101, SWITCHES=1111, second press -> data=0101, overrun=1; data_ack -> data_valid=0, overrun=0.
REQ-035 SHALL cover mid-operation reset: sync_rst during cycle 2 of a debounce -> outputs 0; a held change then takes a full 6 cycles.
